wb_exc_commit: RTL

//  Writeback-stage exception/ERTN commit controller; sits directly upstream of CSR_Unit.
//  - Prioritises per-instruction exception flags and pending interrupts.
//  - Drives CSR_Unit's wb_ex/wb_ecode/wb_esubcode/wb_pc, ertn_flush and gated csr_we.
//  - Issues one redirect to Pre-IF (ex_entry or er_entry) and squashes the pipeline for a fixed drain window.

---
 rtl/wb_exc_commit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/wb_exc_commit.sv
// Writeback-stage exception/ERTN commit controller feeding CSR_Unit.
// Picks the winning trap cause, issues one redirect to Pre-IF and squashes the pipe while it drains.
module wb_exc_commit #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc_in,
    input  logic [31:0] wb_vaddr,
    input  logic        wb_exc_adef,
    input  logic        wb_exc_ine,
    input  logic        wb_exc_sys,
    input  logic        wb_exc_brk,
    input  logic        wb_exc_ale,
    input  logic        wb_is_ertn,
    input  logic        wb_csr_we_in,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] er_entry,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic        ertn_flush,
    output logic        csr_we,
    output logic        badv_we,
    output logic [31:0] badv_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        pipe_flush
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    state_t      state_r;
    logic [3:0]  drain_cnt_r;
    logic        redirect_valid_r;
    logic [31:0] redirect_pc_r;
    logic        flush_r;

    logic        commit_s;
    logic        take_ex_s;
    logic        ertn_take_s;
    logic        badv_sel_s;
    logic [5:0]  ecode_s;

    // Reset also blocks commits so every output reads zero while it is held.
    assign commit_s = (state_r == IDLE) && wb_valid && !reset;

    // Fixed-priority cause select: interrupt first, then fetch-side before execute-side faults.
    always_comb begin
        take_ex_s  = 1'b0;
        badv_sel_s = 1'b0;
        ecode_s    = 6'h00;
        if (!commit_s) begin
            take_ex_s = 1'b0;
        end else if (has_int) begin
            take_ex_s = 1'b1;
            ecode_s   = ECODE_INT;
        end else if (wb_exc_adef) begin
            take_ex_s  = 1'b1;
            badv_sel_s = 1'b1;
            ecode_s    = ECODE_ADEF;
        end else if (wb_exc_ine) begin
            take_ex_s = 1'b1;
            ecode_s   = ECODE_INE;
        end else if (wb_exc_sys) begin
            take_ex_s = 1'b1;
            ecode_s   = ECODE_SYS;
        end else if (wb_exc_brk) begin
            take_ex_s = 1'b1;
            ecode_s   = ECODE_BRK;
        end else if (wb_exc_ale) begin
            take_ex_s  = 1'b1;
            badv_sel_s = 1'b1;
            ecode_s    = ECODE_ALE;
        end else begin
            take_ex_s = 1'b0;
        end
    end

    assign ertn_take_s = commit_s && wb_is_ertn && !take_ex_s;

    assign wb_ex          = take_ex_s;
    assign wb_ecode       = take_ex_s ? ecode_s : 6'h00;
    assign wb_esubcode    = 9'h000;
    assign wb_pc          = take_ex_s ? wb_pc_in : 32'h0000_0000;
    assign ertn_flush     = ertn_take_s;
    assign csr_we         = commit_s && !take_ex_s && !wb_is_ertn && wb_csr_we_in;
    assign badv_we        = take_ex_s && badv_sel_s;
    assign badv_data      = take_ex_s ? wb_vaddr : 32'h0000_0000;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    // The commit cycle itself must already squash younger stages.
    assign pipe_flush     = take_ex_s || ertn_take_s || flush_r;

    // Redirect/drain sequencer with registered handshake and flush outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= IDLE;
            drain_cnt_r      <= 4'd0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'h0000_0000;
            flush_r          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_ex_s || ertn_take_s) begin
                        state_r          <= REDIR;
                        redirect_valid_r <= 1'b1;
                        flush_r          <= 1'b1;
                        redirect_pc_r    <= take_ex_s ? ex_entry : er_entry;
                    end else begin
                        state_r          <= IDLE;
                        redirect_valid_r <= 1'b0;
                        flush_r          <= 1'b0;
                    end
                end
                REDIR: begin
                    if (redirect_ready) begin
                        state_r          <= DRAIN;
                        redirect_valid_r <= 1'b0;
                        drain_cnt_r      <= DRAIN_LOAD;
                    end else begin
                        state_r          <= REDIR;
                    end
                    flush_r <= 1'b1;
                end
                DRAIN: begin
                    if (drain_cnt_r == 4'd0) begin
                        state_r <= IDLE;
                        flush_r <= 1'b0;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - 4'd1;
                        flush_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r          <= IDLE;
                    drain_cnt_r      <= 4'd0;
                    redirect_valid_r <= 1'b0;
                    flush_r          <= 1'b0;
                end
            endcase
        end
    end

endmodule
